// File: rtl/menu_sequencer.sv
// menu_sequencer
//   Screen sequencer for the pong menu. Turns mouse clicks on menu items into
//   settings changes and screen transitions, and times the COUNTDOWN and OVER
//   screens in video frames derived from vsync.
// Ports:
//   clk, rst                 pixel clock, async active-high reset
//   xpos, ypos               mouse position (12-bit, clk domain)
//   mouse_left               left button level
//   vsync_in                 vertical sync from the timing chain
//   game_over                end-of-game level from the game core (PLAY only)
//   state                    MENU=0 COUNTDOWN=1 PLAY=2 OVER=3 CREDITS=4
//   difficulty, mode         persistent menu settings
//   countdown                seconds left while counting down, else 0
//   game_rst                 one-cycle pulse on the first COUNTDOWN cycle
//   game_en                  high while in PLAY
module menu_sequencer #(
    parameter int ITEM_X         = 448,
    parameter int ITEM_W         = 128,
    parameter int START_Y        = 72,
    parameter int DIFF_Y         = 272,
    parameter int MODE_Y         = 472,
    parameter int CREDITS_Y      = 664,
    parameter int ITEM_H         = 16,
    parameter int FRAMES_PER_SEC = 60,
    parameter int OVER_FRAMES    = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        vsync_in,
    input  logic        game_over,
    output logic [2:0]  state,
    output logic        difficulty,
    output logic        mode,
    output logic [1:0]  countdown,
    output logic        game_rst,
    output logic        game_en
);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_OVER      = 3'd3,
        S_CREDITS   = 3'd4
    } state_t;

    localparam logic [11:0] X_LO  = 12'(ITEM_X);
    localparam logic [11:0] X_HI  = 12'(ITEM_X + ITEM_W - 1);
    localparam logic [11:0] ST_LO = 12'(START_Y);
    localparam logic [11:0] ST_HI = 12'(START_Y + ITEM_H - 1);
    localparam logic [11:0] DF_LO = 12'(DIFF_Y);
    localparam logic [11:0] DF_HI = 12'(DIFF_Y + 2 * ITEM_H - 1);
    localparam logic [11:0] MD_LO = 12'(MODE_Y);
    localparam logic [11:0] MD_HI = 12'(MODE_Y + ITEM_H - 1);
    localparam logic [11:0] CR_LO = 12'(CREDITS_Y);
    localparam logic [11:0] CR_HI = 12'(CREDITS_Y + ITEM_H - 1);
    localparam logic [7:0]  FPS_LAST  = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0]  OVER_LAST = 8'(OVER_FRAMES - 1);

    // Input edge detection: level register, then a delayed copy; the rise is
    // registered once more so clicks and ticks reach the FSM two edges after
    // the input is first sampled.
    logic ml_q, ml_prev_q, click_q, click_d;
    logic vs_q, vs_prev_q, tick_q, tick_d;
    logic hit_start_q, hit_diff_q, hit_mode_q, hit_cred_q;
    logic in_x;

    assign click_d = ml_q & ~ml_prev_q;
    assign tick_d  = vs_q & ~vs_prev_q;
    assign in_x    = (xpos >= X_LO) && (xpos <= X_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ml_q        <= 1'b0;
            ml_prev_q   <= 1'b0;
            click_q     <= 1'b0;
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            tick_q      <= 1'b0;
            hit_start_q <= 1'b0;
            hit_diff_q  <= 1'b0;
            hit_mode_q  <= 1'b0;
            hit_cred_q  <= 1'b0;
        end else begin
            ml_q        <= mouse_left;
            ml_prev_q   <= ml_q;
            click_q     <= click_d;
            vs_q        <= vsync_in;
            vs_prev_q   <= vs_q;
            tick_q      <= tick_d;
            // Position is captured alongside the click so the hit matches it.
            hit_start_q <= in_x && (ypos >= ST_LO) && (ypos <= ST_HI);
            hit_diff_q  <= in_x && (ypos >= DF_LO) && (ypos <= DF_HI);
            hit_mode_q  <= in_x && (ypos >= MD_LO) && (ypos <= MD_HI);
            hit_cred_q  <= in_x && (ypos >= CR_LO) && (ypos <= CR_HI);
        end
    end

    state_t      state_q;
    logic        diff_q, mode_q, game_rst_q, game_en_q;
    logic [1:0]  sec_q;
    logic [7:0]  frame_q;

    // One case per cycle: a click is consumed only by the state it lands in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_MENU;
            diff_q     <= 1'b0;
            mode_q     <= 1'b0;
            sec_q      <= 2'd0;
            frame_q    <= 8'd0;
            game_rst_q <= 1'b0;
            game_en_q  <= 1'b0;
        end else begin
            game_rst_q <= 1'b0;
            case (state_q)
                S_MENU: begin
                    if (click_q) begin
                        if (hit_start_q) begin
                            state_q    <= S_COUNTDOWN;
                            sec_q      <= 2'd3;
                            frame_q    <= 8'd0;
                            game_rst_q <= 1'b1;
                        end else if (hit_diff_q) begin
                            diff_q <= ~diff_q;
                        end else if (hit_mode_q) begin
                            mode_q <= ~mode_q;
                        end else if (hit_cred_q) begin
                            state_q <= S_CREDITS;
                        end
                    end
                end
                S_COUNTDOWN: begin
                    if (tick_q) begin
                        if (frame_q == FPS_LAST) begin
                            frame_q <= 8'd0;
                            if (sec_q == 2'd1) begin
                                state_q   <= S_PLAY;
                                sec_q     <= 2'd0;
                                game_en_q <= 1'b1;
                            end else begin
                                sec_q <= sec_q - 2'd1;
                            end
                        end else if (frame_q != 8'hFF) begin
                            frame_q <= frame_q + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (game_over) begin
                        state_q   <= S_OVER;
                        frame_q   <= 8'd0;
                        game_en_q <= 1'b0;
                    end
                end
                S_OVER: begin
                    if (click_q) begin
                        state_q <= S_MENU;
                    end else if (tick_q) begin
                        if (frame_q == OVER_LAST) begin
                            state_q <= S_MENU;
                        end else if (frame_q != 8'hFF) begin
                            frame_q <= frame_q + 8'd1;
                        end
                    end
                end
                S_CREDITS: begin
                    if (click_q) state_q <= S_MENU;
                end
                default: begin
                    state_q   <= S_MENU;
                    game_en_q <= 1'b0;
                    sec_q     <= 2'd0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign difficulty = diff_q;
    assign mode       = mode_q;
    assign countdown  = sec_q;
    assign game_rst   = game_rst_q;
    assign game_en    = game_en_q;

endmodule

// File: tb/tb_menu_sequencer.sv
module tb_menu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic        mouse_left, vsync_in, game_over;
    logic [2:0]  state;
    logic        difficulty, mode, game_rst, game_en;
    logic [1:0]  countdown;

    int tests = 0;
    int fails = 0;

    menu_sequencer #(.FRAMES_PER_SEC(2), .OVER_FRAMES(4)) dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .mouse_left(mouse_left), .vsync_in(vsync_in), .game_over(game_over),
        .state(state), .difficulty(difficulty), .mode(mode),
        .countdown(countdown), .game_rst(game_rst), .game_en(game_en)
    );

    always #5 clk = ~clk;

    // Stimulus drivers (no checking inside).
    task automatic click(input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        xpos = x; ypos = y; mouse_left = 1'b1;
        repeat (3) @(negedge clk);
        mouse_left = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic vpulse();
        @(negedge clk);
        vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        vsync_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; xpos = 0; ypos = 0; mouse_left = 0; vsync_in = 0; game_over = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({state, difficulty, mode, countdown, game_rst, game_en} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: got state=%0d diff=%0d mode=%0d cd=%0d grst=%0d gen=%0d want all 0",
                     state, difficulty, mode, countdown, game_rst, game_en);
        end
    endtask

    task automatic test_settings();
        click(500, 300);
        tests++;
        if (difficulty !== 1'b1) begin fails++; $display("FAIL diff_toggle1: got %0d want 1", difficulty); end
        click(500, 300);
        tests++;
        if (difficulty !== 1'b0) begin fails++; $display("FAIL diff_toggle2: got %0d want 0", difficulty); end
        click(500, 475);
        tests++;
        if (mode !== 1'b1) begin fails++; $display("FAIL mode_toggle: got %0d want 1", mode); end
        click(447, 80);
        tests++;
        if (state !== 3'd0) begin fails++; $display("FAIL miss_left: got state %0d want 0", state); end
        click(576, 80);
        tests++;
        if (state !== 3'd0 || difficulty !== 1'b0 || mode !== 1'b1) begin
            fails++;
            $display("FAIL miss_right: got state=%0d diff=%0d mode=%0d want 0/0/1", state, difficulty, mode);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        xpos = 500; ypos = 280; mouse_left = 1'b1;
        repeat (1000) @(negedge clk);
        tests++;
        if (difficulty !== 1'b1) begin fails++; $display("FAIL hold_once: got %0d want 1", difficulty); end
        mouse_left = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (difficulty !== 1'b1) begin fails++; $display("FAIL hold_release: got %0d want 1", difficulty); end
    endtask

    // Click at (x,y) on START and check the exact latency and game_rst pulse.
    task automatic test_start_latency(input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        xpos = x; ypos = y; mouse_left = 1'b1;
        @(negedge clk);   // edge N has registered the button
        @(negedge clk);   // edge N+1: click detected
        tests++;
        if (state !== 3'd0 || game_rst !== 1'b0) begin
            fails++; $display("FAIL start_early: got state=%0d grst=%0d want 0/0", state, game_rst);
        end
        @(negedge clk);   // edge N+2
        tests++;
        if (state !== 3'd1 || game_rst !== 1'b1 || countdown !== 2'd3 || game_en !== 1'b0) begin
            fails++;
            $display("FAIL start_enter: got state=%0d grst=%0d cd=%0d gen=%0d want 1/1/3/0",
                     state, game_rst, countdown, game_en);
        end
        @(negedge clk);
        tests++;
        if (game_rst !== 1'b0 || state !== 3'd1) begin
            fails++; $display("FAIL start_pulse_width: got grst=%0d state=%0d want 0/1", game_rst, state);
        end
        mouse_left = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_countdown();
        logic [1:0] exp_cd [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (state !== 3'd1 || countdown !== exp_cd[i]) begin
                fails++;
                $display("FAIL countdown_step%0d: got state=%0d cd=%0d want 1/%0d", i, state, countdown, exp_cd[i]);
            end
            vpulse();
        end
        tests++;
        if (state !== 3'd2 || game_en !== 1'b1 || countdown !== 2'd0) begin
            fails++;
            $display("FAIL enter_play: got state=%0d gen=%0d cd=%0d want 2/1/0", state, game_en, countdown);
        end
    endtask

    task automatic test_over_timeout();
        click(450, 80);   // ignored in PLAY
        tests++;
        if (state !== 3'd2) begin fails++; $display("FAIL play_ignores_click: got %0d want 2", state); end
        @(negedge clk); game_over = 1'b1;
        @(negedge clk); game_over = 1'b0;
        tests++;
        if (state !== 3'd3 || game_en !== 1'b0) begin
            fails++; $display("FAIL enter_over: got state=%0d gen=%0d want 3/0", state, game_en);
        end
        repeat (3) vpulse();
        tests++;
        if (state !== 3'd3) begin fails++; $display("FAIL over_hold: got %0d want 3", state); end
        vpulse();
        tests++;
        if (state !== 3'd0) begin fails++; $display("FAIL over_timeout: got %0d want 0", state); end
    endtask

    task automatic test_over_click();
        click(450, 80);
        repeat (6) vpulse();
        @(negedge clk); game_over = 1'b1;
        @(negedge clk); game_over = 1'b0;
        vpulse();
        @(negedge clk);
        xpos = 10; ypos = 10; mouse_left = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (state !== 3'd3) begin fails++; $display("FAIL over_click_early: got %0d want 3", state); end
        @(negedge clk);
        tests++;
        if (state !== 3'd0) begin fails++; $display("FAIL over_click: got %0d want 0", state); end
        mouse_left = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 3'd0 || difficulty !== 1'b1 || mode !== 1'b1) begin
            fails++;
            $display("FAIL settings_persist: got state=%0d diff=%0d mode=%0d want 0/1/1", state, difficulty, mode);
        end
    endtask

    task automatic test_credits();
        click(450, 670);
        tests++;
        if (state !== 3'd4) begin fails++; $display("FAIL enter_credits: got %0d want 4", state); end
        click(0, 0);
        tests++;
        if (state !== 3'd0) begin fails++; $display("FAIL leave_credits: got %0d want 0", state); end
    endtask

    task automatic test_async_reset();
        click(450, 80);
        tests++;
        if (state !== 3'd1) begin fails++; $display("FAIL pre_reset_cd: got %0d want 1", state); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({state, difficulty, mode, countdown, game_rst, game_en} !== 9'd0) begin
            fails++;
            $display("FAIL async_reset: got state=%0d diff=%0d mode=%0d cd=%0d grst=%0d gen=%0d want all 0",
                     state, difficulty, mode, countdown, game_rst, game_en);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (state !== 3'd0 || game_rst !== 1'b0) begin
                fails++; $display("FAIL post_reset%0d: got state=%0d grst=%0d want 0/0", i, state, game_rst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_settings();
        test_hold();
        test_start_latency(575, 87);
        test_countdown();
        test_over_timeout();
        test_over_click();
        test_credits();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/menu_sequencer.md
# menu_sequencer

Top-level screen sequencer for the pong menu. Turns mouse position plus left-button clicks into menu selections. Holds the difficulty and mode settings fed to the menu text ROMs and the game core. Steps the design through MENU, COUNTDOWN, PLAY, OVER and CREDITS, timing on-screen intervals in video frames taken from vsync. Sits beside `menu_ctl`, takes the same mouse coordinates, and drives the screen mux and game-core enables.

## Interface
Parameters:
- ITEM_X, 448, left edge (px) of all clickable items
- ITEM_W, 128, width (px) of all clickable items
- START_Y, 72, top of START item; height ITEM_H
- DIFF_Y, 272, top of DIFFICULTY item; height 2*ITEM_H
- MODE_Y, 472, top of MODE item; height ITEM_H
- CREDITS_Y, 664, top of CREDITS item; height ITEM_H
- ITEM_H, 16, single-line item height (px)
- FRAMES_PER_SEC, 60, frames per countdown step
- OVER_FRAMES, 120, frames the OVER screen is held

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- xpos  in  12  mouse x, clk domain
- ypos  in  12  mouse y, clk domain
- mouse_left  in  1  left button level, clk domain
- vsync_in  in  1  vertical sync from timing chain
- game_over  in  1  level from game core, sampled only in PLAY
- state  out  3  MENU=0, COUNTDOWN=1, PLAY=2, OVER=3, CREDITS=4
- difficulty  out  1  0 easy, 1 hard
- mode  out  1  0 one player, 1 two players
- countdown  out  2  seconds left in COUNTDOWN (3..1), 0 otherwise
- game_rst  out  1  one-cycle pulse on entry to COUNTDOWN
- game_en  out  1  high only in PLAY

## Operation
- Click detection: register `mouse_left`. A click is a 0->1 transition. Exactly one click event per press. Held button never repeats.
- Hit test: `xpos` in [ITEM_X, ITEM_X+ITEM_W-1] and `ypos` in [top, top+height-1], inclusive. Compare at 12 bits, unsigned. Parameter sums must fit in 12 bits.
- Regions do not overlap. At most one hit per click.
- Frame tick: one-cycle pulse on each rising edge of registered `vsync_in`.
- FSM, with all transitions registered:
  - MENU
    - START click -> COUNTDOWN. Loads sec=3 and frame counter=0, asserts `game_rst`.
    - DIFF click toggles `difficulty`.
    - MODE click toggles `mode`.
    - CREDITS click -> CREDITS.
    - Click outside all regions: no effect.
  - COUNTDOWN
    - Frame counter increments per tick.
    - At FRAMES_PER_SEC-1 the counter wraps to 0 and sec decrements.
    - A wrap with sec=1 -> PLAY.
    - Clicks are ignored.
  - PLAY
    - `game_over`=1 -> OVER, frame counter=0.
    - Clicks are ignored.
  - OVER
    - Counts ticks. At OVER_FRAMES-1 -> MENU.
    - A click -> MENU immediately.
  - CREDITS: any click anywhere -> MENU.
- `difficulty` and `mode` are held in every state except MENU clicks. They persist across games.
- Frame counter is 8 bits. The counter saturates and never wraps unintentionally.

## Timing
- Reset (async assert, removal at clk edge) sets:
  - state=MENU
  - difficulty=0, mode=0
  - countdown=0
  - game_rst=0, game_en=0
  - all internal counters and edge registers 0
- Reset mid-COUNTDOWN or mid-PLAY returns to MENU with no `game_rst` pulse.
- Click latency: `mouse_left` rising at edge N is registered at N. The click is detected at N+1, and state/setting outputs change at edge N+2.
- `game_rst` is high for exactly the cycle `state` first reads COUNTDOWN.
- `game_en` is registered and equals (state==PLAY) in the same cycle.
- Frame tick latency: vsync rising edge -> tick 2 cycles later. Ticks are independent of clicks.
- COUNTDOWN lasts exactly 3*FRAMES_PER_SEC ticks.
- `countdown` shows 3, 2, 1 in turn and reads 0 in the same cycle PLAY is entered.
- Simultaneous tick and click in OVER: the click wins, giving MENU.
- Simultaneous `game_over` and click in PLAY: OVER is entered.
- A click that coincides with leaving a state is consumed by that state only. No double action.

## Test plan
- Reset, then click at (450,80) -> state MENU->COUNTDOWN at click+2 cycles, one `game_rst` pulse, countdown=3.
- FRAMES_PER_SEC=2, from COUNTDOWN drive 6 vsync pulses -> countdown 3,3,2,2,1,1 then state=PLAY, game_en=1, countdown=0.
- In MENU:
  - click (500,300) twice -> difficulty 0->1->0.
  - click (500,475) -> mode=1.
  - click (447,80) and (576,80) -> no change (boundary miss).
  - click (575,87) -> COUNTDOWN (boundary hit).
- Hold mouse_left for 1000 cycles over DIFF -> difficulty toggles exactly once.
- In PLAY, assert game_over -> OVER. With OVER_FRAMES=4, 4 vsync pulses -> MENU. Repeat with a click after 1 pulse -> MENU at click+2.
- Click (450,670) -> CREDITS. Click (0,0) -> MENU. Assert rst asynchronously during COUNTDOWN -> all outputs at reset values immediately, without a clock edge.
